// File: rtl/tlul_arb_pkg.sv
// Shared types and helpers for the TL-UL M:1 weighted round-robin arbiter.
//   arb_state_e : arbiter mode (idle scan vs. owner burst)
//   MaxHosts    : widest host vector the pick helper handles
//   rr_pick     : rotate-and-find-first over an eligibility vector
package tlul_arb_pkg;

    typedef enum logic {
        ArbIdle  = 1'b0,
        ArbBurst = 1'b1
    } arb_state_e;

    localparam int MaxHosts = 16;

    // First set bit of elig scanning last+1, last+2, ... modulo m.
    // The scan ends on last itself, so a lone requester can be re-picked.
    // Returns 0 when nothing is eligible.
    function automatic logic [3:0] rr_pick(input logic [MaxHosts-1:0] elig,
                                           input logic [3:0]          last,
                                           input int                  m);
        logic [3:0] res;
        logic       found;
        int         j;
        res   = '0;
        found = 1'b0;
        for (int k = 1; k <= MaxHosts; k++) begin
            j = int'(last) + k;
            if (j >= m) j = j - m;
            if (k <= m && !found && elig[j[3:0]]) begin
                res   = j[3:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tlul_m1_wrr_arbiter_if.sv
// Request/response handshake bundle between the host FIFOs, the arbiter
// and the device path.
//   req_i/weight_i/a_ready_i : host requests, per-host weights, device ready
//   valid_o/idx_o/gnt_o      : arbitrated valid, mux select, one-hot grant
//   rsp_valid_i/rsp_ready_i/rsp_idx_i : device response handshake + host index
// Modport slave is the arbiter side; master is the surrounding logic.
interface tlul_m1_wrr_arbiter_if #(
    parameter int M       = 4,
    parameter int WeightW = 4
);
    localparam int IdxW = $clog2(M);

    logic [M-1:0]         req_i;
    logic [M*WeightW-1:0] weight_i;
    logic                 a_ready_i;
    logic                 valid_o;
    logic [IdxW-1:0]      idx_o;
    logic [M-1:0]         gnt_o;
    logic                 rsp_valid_i;
    logic                 rsp_ready_i;
    logic [IdxW-1:0]      rsp_idx_i;

    modport slave (
        input  req_i, weight_i, a_ready_i, rsp_valid_i, rsp_ready_i, rsp_idx_i,
        output valid_o, idx_o, gnt_o
    );

    modport master (
        output req_i, weight_i, a_ready_i, rsp_valid_i, rsp_ready_i, rsp_idx_i,
        input  valid_o, idx_o, gnt_o
    );
endinterface

// File: rtl/tlul_arb_credit_cnt.sv
// Per-host in-flight request counter, saturating at 0 and MaxCnt.
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : request accepted for this host
//   dec_i        : response handshake for this host
//   cnt_o        : current in-flight count
//   full_o       : count reached MaxCnt (host out of credit)
//   underflow_o  : dec_i while already empty (combinational)
module tlul_arb_credit_cnt #(
    parameter int MaxCnt = 2,
    parameter int CntW   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            full_o,
    output logic            underflow_o
);
    logic [CntW-1:0] r_cnt;
    logic            w_dec_ok;

    assign w_dec_ok    = dec_i & (r_cnt != '0);
    assign full_o      = (r_cnt == CntW'(MaxCnt));
    assign underflow_o = dec_i & (r_cnt == '0);
    assign cnt_o       = r_cnt;

    // inc together with a real dec cancels out
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && !w_dec_ok && !full_o) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (w_dec_ok && !inc_i) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/tlul_m1_wrr_arbiter.sv
// Weighted round-robin request arbiter with per-host credit limits for the
// TL-UL M:1 socket.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus           : request/response handshake bundle (slave side)
//   outstanding_o : per-host in-flight count, host i at [i*CntW+:CntW]
//   stall_o       : host requesting but out of credit
//   err_o         : registered pulse on response to an idle or invalid host
module tlul_m1_wrr_arbiter
    import tlul_arb_pkg::*;
#(
    parameter int  M              = 4,
    parameter int  MaxOutstanding = 2,
    parameter int  WeightW        = 4,
    localparam int IdxW           = $clog2(M),
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    tlul_m1_wrr_arbiter_if.slave    bus,
    output logic [M*CntW-1:0]       outstanding_o,
    output logic [M-1:0]            stall_o,
    output logic                    err_o
);
    logic [M-1:0][WeightW-1:0] w_weight;
    logic [M-1:0][CntW-1:0]    w_cnt;
    logic [M-1:0]              w_full, w_unf, w_inc, w_dec, w_elig, w_onehot;
    logic                      w_valid, w_accept, w_rsp_hs, w_rsp_oor;
    logic [IdxW-1:0]           w_sel, r_ptr, w_ptr_nxt;
    logic [WeightW-1:0]        r_burst_left, w_bl_nxt, w_reload;
    arb_state_e                r_state, w_state_nxt;
    logic                      r_err;

    assign w_weight = bus.weight_i;
    assign w_elig   = bus.req_i & ~w_full;
    assign stall_o  = bus.req_i & w_full;
    assign w_accept = (|w_elig) & bus.a_ready_i;
    assign w_rsp_hs = bus.rsp_valid_i & bus.rsp_ready_i;

    // Only a non-power-of-two M leaves unused index codes to flag.
    if (M < (1 << IdxW)) begin : g_oor
        assign w_rsp_oor = (bus.rsp_idx_i >= IdxW'(M));
    end else begin : g_no_oor
        assign w_rsp_oor = 1'b0;
    end

    for (genvar g = 0; g < M; g++) begin : g_cnt
        assign w_inc[g] = w_accept & (w_sel == IdxW'(g));
        assign w_dec[g] = w_rsp_hs & ~w_rsp_oor & (bus.rsp_idx_i == IdxW'(g));
        tlul_arb_credit_cnt #(
            .MaxCnt (MaxOutstanding),
            .CntW   (CntW)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .inc_i       (w_inc[g]),
            .dec_i       (w_dec[g]),
            .cnt_o       (w_cnt[g]),
            .full_o      (w_full[g]),
            .underflow_o (w_unf[g])
        );
    end

    assign outstanding_o = w_cnt;

    // Burst length for the host being (re)loaded; weight 0 behaves as 1.
    assign w_reload = (w_weight[w_sel] == '0) ? '0 : w_weight[w_sel] - 1'b1;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ArbIdle;
            r_ptr        <= IdxW'(M - 1);
            r_burst_left <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_burst_left <= w_bl_nxt;
            r_err        <= w_rsp_hs & (w_rsp_oor | (|w_unf));
        end
    end

    // Next state: moves only on accept. In BURST, sel == ptr exactly when
    // the owner is still eligible; otherwise the new winner reloads.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_bl_nxt    = r_burst_left;
        if (w_accept) begin
            if (r_state == ArbBurst && w_sel == r_ptr) begin
                w_bl_nxt    = r_burst_left - 1'b1;
                w_state_nxt = (r_burst_left == WeightW'(1)) ? ArbIdle : ArbBurst;
            end else begin
                w_ptr_nxt   = w_sel;
                w_bl_nxt    = w_reload;
                w_state_nxt = (w_reload != '0) ? ArbBurst : ArbIdle;
            end
        end
    end

    // Outputs: zero-latency pick, the burst owner keeps priority
    always_comb begin
        w_sel = IdxW'(rr_pick(MaxHosts'(w_elig), 4'(r_ptr), M));
        if (r_state == ArbBurst && w_elig[r_ptr]) w_sel = r_ptr;
        w_valid     = |w_elig;
        w_onehot    = {{(M-1){1'b0}}, 1'b1} << w_sel;
        bus.valid_o = w_valid;
        bus.idx_o   = w_sel;
        bus.gnt_o   = w_onehot & {M{w_valid & bus.a_ready_i}};
    end

    assign err_o = r_err;
endmodule

// File: tb/tb_tlul_m1_wrr_arbiter.sv
module tb_tlul_m1_wrr_arbiter;
    localparam int M  = 4;
    localparam int MO = 2;
    localparam int WW = 4;
    localparam int IW = 2;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlul_m1_wrr_arbiter_if #(.M(M), .WeightW(WW)) bus ();
    logic [M*CW-1:0] outstanding;
    logic [M-1:0]    stall;
    logic            err;

    tlul_m1_wrr_arbiter #(.M(M), .MaxOutstanding(MO), .WeightW(WW)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .outstanding_o(outstanding), .stall_o(stall), .err_o(err));

    // Five-host instance: only place where an out-of-range index is encodable.
    tlul_m1_wrr_arbiter_if #(.M(5), .WeightW(WW)) bus5 ();
    logic [5*CW-1:0] outstanding5;
    logic [4:0]      stall5;
    logic            err5;

    tlul_m1_wrr_arbiter #(.M(5), .MaxOutstanding(MO), .WeightW(WW)) dut5 (
        .clk_i(clk), .rst_i(rst), .bus(bus5),
        .outstanding_o(outstanding5), .stall_o(stall5), .err_o(err5));

    int checks = 0;
    int errors = 0;

    // Reference model: credits per host, current burst owner (-1 = none)
    // with grants remaining, and last granted host.
    int cnt_m[M];
    int owner, remaining, last;
    logic exp_err;
    logic exp_valid;
    logic [IW-1:0] exp_idx;
    logic [M-1:0] exp_gnt, exp_stall, exp_elig;
    logic [M*CW-1:0] exp_out;
    int exp_sel;

    int rr_seq[5] = '{0, 1, 2, 3, 0};
    int wt_seq[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};

    task automatic model_reset();
        for (int i = 0; i < M; i++) cnt_m[i] = 0;
        owner = -1; remaining = 0; last = M - 1; exp_err = 1'b0;
    endtask

    task automatic model_eval();
        logic found;
        logic [M-1:0] one;
        one = 1;
        exp_elig = '0;
        for (int i = 0; i < M; i++)
            if (bus.req_i[i] && cnt_m[i] < MO) exp_elig[i] = 1'b1;
        exp_stall = bus.req_i & ~exp_elig;
        exp_valid = |exp_elig;
        exp_sel = 0;
        found = 1'b0;
        if (owner >= 0 && exp_elig[owner]) begin
            exp_sel = owner;
        end else begin
            for (int k = 1; k <= M; k++)
                if (!found && exp_elig[(last + k) % M]) begin
                    exp_sel = (last + k) % M;
                    found = 1'b1;
                end
        end
        exp_idx = IW'(exp_sel);
        exp_gnt = (exp_valid && bus.a_ready_i) ? (one << exp_sel) : '0;
        for (int i = 0; i < M; i++) exp_out[i*CW +: CW] = CW'(cnt_m[i]);
    endtask

    task automatic model_update();
        logic err_n, dec_n;
        int ri, w;
        if (rst) begin
            model_reset();
            return;
        end
        model_eval();
        err_n = 1'b0; dec_n = 1'b0;
        ri = int'(bus.rsp_idx_i);
        if (bus.rsp_valid_i && bus.rsp_ready_i) begin
            if (ri >= M) err_n = 1'b1;
            else if (cnt_m[ri] == 0) err_n = 1'b1;
            else dec_n = 1'b1;
        end
        if (exp_valid && bus.a_ready_i) begin
            cnt_m[exp_sel]++;
            if (owner == exp_sel) begin
                remaining--;
                if (remaining == 0) owner = -1;
            end else begin
                w = int'(bus.weight_i[exp_sel*WW +: WW]);
                if (w == 0) w = 1;
                remaining = w - 1;
                owner = (remaining > 0) ? exp_sel : -1;
            end
            last = exp_sel;
        end
        if (dec_n) cnt_m[ri]--;
        exp_err = err_n;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic quiet();
        bus.req_i = '0; bus.weight_i = 16'h1111; bus.a_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0; bus.rsp_ready_i = 1'b1; bus.rsp_idx_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if ({bus.valid_o, bus.gnt_o, bus.idx_o, stall, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b gnt=%b idx=%0d stall=%b err=%b expected all 0",
                     bus.valid_o, bus.gnt_o, bus.idx_o, stall, err);
        end
        checks++;
        if (outstanding !== '0) begin
            errors++;
            $display("FAIL reset_outstanding: got %h expected 0", outstanding);
        end
    endtask

    task automatic test_rr();
        int prev;
        do_reset();
        bus.req_i = 4'hf; bus.a_ready_i = 1'b1; prev = -1;
        for (int c = 0; c < 5; c++) begin
            bus.rsp_valid_i = (prev >= 0);
            bus.rsp_idx_i = IW'((prev >= 0) ? prev : 0);
            settle();
            checks++;
            if (bus.idx_o !== IW'(rr_seq[c]) || bus.gnt_o !== (4'b0001 << rr_seq[c])) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got idx=%0d gnt=%b expected idx=%0d", c, bus.idx_o, bus.gnt_o, rr_seq[c]);
            end
            checks++;
            if (err !== exp_err || outstanding !== exp_out) begin
                errors++;
                $display("FAIL rr_credit[%0d]: got err=%b out=%h expected err=%b out=%h", c, err, outstanding, exp_err, exp_out);
            end
            prev = int'(bus.idx_o);
            tick();
        end
    endtask

    task automatic test_weight();
        int prev;
        do_reset();
        bus.req_i = 4'hf; bus.a_ready_i = 1'b1; bus.weight_i = 16'h1113; prev = -1;
        for (int c = 0; c < 9; c++) begin
            bus.rsp_valid_i = (prev >= 0);
            bus.rsp_idx_i = IW'((prev >= 0) ? prev : 0);
            settle();
            checks++;
            if (bus.idx_o !== IW'(wt_seq[c]) || bus.gnt_o !== (4'b0001 << wt_seq[c])) begin
                errors++;
                $display("FAIL wt_seq[%0d]: got idx=%0d gnt=%b expected idx=%0d", c, bus.idx_o, bus.gnt_o, wt_seq[c]);
            end
            prev = int'(bus.idx_o);
            tick();
        end
    endtask

    task automatic test_credit();
        do_reset();
        bus.req_i = 4'b0010; bus.a_ready_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (bus.gnt_o !== 4'b0010) begin
                errors++;
                $display("FAIL credit_accept[%0d]: got gnt=%b expected 0010", c, bus.gnt_o);
            end
            tick();
        end
        bus.rsp_valid_i = 1'b1; bus.rsp_idx_i = 2'd1;
        settle();
        checks++;
        if (bus.valid_o !== 1'b0 || stall !== 4'b0010 || outstanding[CW +: CW] !== 2'd2) begin
            errors++;
            $display("FAIL credit_full: got valid=%b stall=%b cnt1=%0d expected 0 0010 2", bus.valid_o, stall, outstanding[CW +: CW]);
        end
        tick();
        bus.rsp_valid_i = 1'b0;
        settle();
        checks++;
        if (outstanding[CW +: CW] !== 2'd1 || bus.gnt_o !== 4'b0010) begin
            errors++;
            $display("FAIL credit_return: got cnt1=%0d gnt=%b expected 1 0010", outstanding[CW +: CW], bus.gnt_o);
        end
        tick();
        settle();
        checks++;
        if (outstanding[CW +: CW] !== 2'd2 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL credit_refill: got cnt1=%0d valid=%b expected 2 0", outstanding[CW +: CW], bus.valid_o);
        end
    endtask

    task automatic test_stall();
        do_reset();
        bus.req_i = 4'b0101; bus.a_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (bus.valid_o !== 1'b1 || bus.gnt_o !== 4'b0000 || bus.idx_o !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b gnt=%b idx=%0d expected 1 0000 0", c, bus.valid_o, bus.gnt_o, bus.idx_o);
            end
            tick();
        end
        bus.a_ready_i = 1'b1;
        settle();
        checks++;
        if (bus.gnt_o !== 4'b0001) begin
            errors++;
            $display("FAIL stall_release: got gnt=%b expected 0001", bus.gnt_o);
        end
        tick();
        settle();
        checks++;
        if (bus.gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL stall_next: got gnt=%b expected 0100", bus.gnt_o);
        end
        tick();
    endtask

    task automatic test_collide();
        do_reset();
        bus.req_i = 4'b0100; bus.a_ready_i = 1'b1;
        tick();
        bus.rsp_valid_i = 1'b1; bus.rsp_idx_i = 2'd2;
        settle();
        checks++;
        if (bus.gnt_o !== 4'b0100) begin
            errors++;
            $display("FAIL collide_gnt: got gnt=%b expected 0100", bus.gnt_o);
        end
        tick();
        bus.req_i = '0; bus.rsp_idx_i = 2'd3;
        settle();
        checks++;
        if (outstanding[2*CW +: CW] !== 2'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL collide_cnt: got cnt2=%0d err=%b expected 1 0", outstanding[2*CW +: CW], err);
        end
        tick();
        bus.rsp_valid_i = 1'b0;
        settle();
        checks++;
        if (err !== 1'b1 || outstanding[3*CW +: CW] !== 2'd0) begin
            errors++;
            $display("FAIL underflow_err: got err=%b cnt3=%0d expected 1 0", err, outstanding[3*CW +: CW]);
        end
        tick();
        settle();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pulse: got err=%b expected 0", err);
        end
    endtask

    task automatic test_oor();
        bus5.rsp_valid_i = 1'b1; bus5.rsp_ready_i = 1'b1; bus5.rsp_idx_i = 3'd5;
        tick();
        checks++;
        if (err5 !== 1'b1) begin
            errors++;
            $display("FAIL oor_idx5: got err=%b expected 1", err5);
        end
        bus5.rsp_ready_i = 1'b0; bus5.rsp_idx_i = 3'd6;
        tick();
        checks++;
        if (err5 !== 1'b0) begin
            errors++;
            $display("FAIL oor_no_hs: got err=%b expected 0", err5);
        end
        bus5.rsp_valid_i = 1'b0;
        settle();
        checks++;
        if ({bus5.valid_o, bus5.gnt_o, bus5.idx_o, stall5, outstanding5} !== '0) begin
            errors++;
            $display("FAIL oor_counters: got out=%h stall=%b valid=%b expected 0", outstanding5, stall5, bus5.valid_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req_i = 4'hf; bus.a_ready_i = 1'b1; bus.weight_i = 16'h1113;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_i = '0; bus.rsp_valid_i = 1'b1; bus.rsp_idx_i = 2'd0;
        settle();
        checks++;
        if (outstanding !== '0 || bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got out=%h valid=%b expected 0 0", outstanding, bus.valid_o);
        end
        tick();
        bus.rsp_valid_i = 1'b0; bus.req_i = 4'hf; bus.weight_i = 16'h1111;
        settle();
        checks++;
        if (err !== 1'b1 || bus.idx_o !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_late_rsp: got err=%b idx=%0d expected 1 0", err, bus.idx_o);
        end
        tick();
        settle();
        checks++;
        if (bus.idx_o !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_idle: got idx=%0d expected 1", bus.idx_o);
        end
        tick();
    endtask

    task automatic test_random();
        int cand;
        logic found;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.req_i = M'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus.weight_i = 16'($urandom);
            bus.a_ready_i = ($urandom_range(0, 3) != 0);
            bus.rsp_valid_i = ($urandom_range(0, 1) != 0);
            bus.rsp_ready_i = ($urandom_range(0, 4) != 0);
            cand = $urandom_range(0, M - 1);
            found = 1'b0;
            if ($urandom_range(0, 4) != 0)
                for (int i = 0; i < M; i++)
                    if (!found && cnt_m[(cand + i) % M] > 0) begin
                        cand = (cand + i) % M;
                        found = 1'b1;
                    end
            bus.rsp_idx_i = IW'(cand);
            settle();
            checks++;
            if (bus.valid_o !== exp_valid || bus.idx_o !== exp_idx || bus.gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL rand_pick[%0d]: got valid=%b idx=%0d gnt=%b expected %b %0d %b",
                         c, bus.valid_o, bus.idx_o, bus.gnt_o, exp_valid, exp_idx, exp_gnt);
            end
            checks++;
            if (stall !== exp_stall || outstanding !== exp_out || err !== exp_err) begin
                errors++;
                $display("FAIL rand_credit[%0d]: got stall=%b out=%h err=%b expected %b %h %b",
                         c, stall, outstanding, err, exp_stall, exp_out, exp_err);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        bus5.req_i = '0; bus5.weight_i = '0; bus5.a_ready_i = 1'b0;
        bus5.rsp_valid_i = 1'b0; bus5.rsp_ready_i = 1'b0; bus5.rsp_idx_i = '0;
        model_reset();
        test_reset();
        test_rr();
        test_weight();
        test_credit();
        test_stall();
        test_collide();
        test_oor();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
